ofdm_subc_mapper: RTL and testbench

OFDM_SUBC_MAPPER -- requirements
Module: ofdm_subc_mapper

---
 rtl/ofdm_subc_mapper.sv | 255 +++++++++++++++++++++++++
 tb/tb_ofdm_subc_mapper.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_subc_mapper.sv
// Maps payload bits to signed I/Q per subcarrier type and latched modulation mode.
// Two-cycle latency, with a one-entry skid buffer. Define MAPPER_NOISE_EN to add LFSR dither to non-guard samples.
module ofdm_subc_mapper #(
  parameter int MAXBITS = 6,
  parameter int DW      = 12,
  parameter int FFT_N   = 1024,
  parameter int A_QPSK  = 1024,
  parameter int A_Q16   = 512,
  parameter int A_Q64   = 256,
  parameter int A_PIL   = 2000,
  parameter int A_PRE   = 1024,
  parameter int NOISE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ival,
  output logic                 ordy,
  input  logic                 isop,
  input  logic                 ieop,
  input  logic [MAXBITS-1:0]   bits,
  input  logic [2:0]           index_M,
  input  logic [1:0]           index_subc,
  output logic signed [DW-1:0] sub_i,
  output logic signed [DW-1:0] sub_q,
  output logic                 oval,
  input  logic                 irdy,
  output logic                 osop,
  output logic                 oeop,
  output logic [2:0]           oindex_M,
  output logic [1:0]           oindex_subc,
  output logic                 err_frame,
  output logic                 err_mode
);

  localparam int CW = (FFT_N > 1) ? $clog2(FFT_N) : 1;
  localparam int SMAX = (2 ** (DW - 1)) - 1;
  localparam int SMIN = -(2 ** (DW - 1));
  localparam logic [CW-1:0] LAST = CW'(FFT_N - 1);

  typedef struct packed {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic                 sop;
    logic                 eop;
    logic [2:0]           m;
    logic [1:0]           subc;
  } samp_t;

  function automatic int lvl2(input logic [1:0] g);
    int r;
    case (g)
      2'b00:   r = -3;
      2'b01:   r = -1;
      2'b11:   r = 1;
      default: r = 3;
    endcase
    return r;
  endfunction

  function automatic int lvl3(input logic [2:0] g);
    int r;
    case (g)
      3'b000:  r = -7;
      3'b001:  r = -5;
      3'b011:  r = -3;
      3'b010:  r = -1;
      3'b110:  r = 1;
      3'b111:  r = 3;
      3'b101:  r = 5;
      default: r = 7;
    endcase
    return r;
  endfunction

  function automatic logic signed [DW-1:0] sat(input int v);
    logic signed [DW-1:0] r;
    if (v > SMAX)      r = DW'(SMAX);
    else if (v < SMIN) r = DW'(SMIN);
    else               r = DW'(v);
    return r;
  endfunction

  logic              acc;
  logic [2:0]        mode_q;
  logic [2:0]        mode_eff;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cur_idx;
  logic              eop_seen_q;
  logic [5:0]        b6;
  int                map_i;
  int                map_q;
  logic [2:0]        map_m;
  logic              mode_ok;
  int                add_i;
  int                add_q;
  logic signed [NOISE_W-1:0] nz_i;
  logic signed [NOISE_W-1:0] nz_q;
  samp_t             new_s;

  samp_t map_s, skid_s, out_s;
  logic  map_vld, skid_vld, out_vld;
  logic  out_adv, take_skid, take_map, map_to_skid;

  assign ordy     = !(skid_vld && out_vld);
  assign acc      = ival && ordy;
  assign mode_eff = isop ? index_M : mode_q;
  assign cur_idx  = isop ? '0 : cnt_q;
  assign b6       = 6'(bits);
  assign mode_ok  = (mode_eff == 3'd1) || (mode_eff == 3'd2) ||
                    (mode_eff == 3'd4) || (mode_eff == 3'd6);

  always_comb begin
    map_i = 0;
    map_q = 0;
    map_m = 3'd0;
    case (index_subc)
      2'd1: begin
        case (mode_eff)
          3'd1: begin
            map_i = b6[0] ? -A_QPSK : A_QPSK;
            map_m = 3'd1;
          end
          3'd2: begin
            map_i = b6[1] ? -A_QPSK : A_QPSK;
            map_q = b6[0] ? -A_QPSK : A_QPSK;
            map_m = 3'd2;
          end
          3'd4: begin
            map_i = lvl2(b6[3:2]) * A_Q16;
            map_q = lvl2(b6[1:0]) * A_Q16;
            map_m = 3'd4;
          end
          3'd6: begin
            map_i = lvl3(b6[5:3]) * A_Q64;
            map_q = lvl3(b6[2:0]) * A_Q64;
            map_m = 3'd6;
          end
          default: ;
        endcase
      end
      2'd2: begin
        map_i = b6[1] ? -A_PIL : A_PIL;
        map_q = b6[0] ? -A_PIL : A_PIL;
        map_m = 3'd2;
      end
      2'd3: begin
        map_i = b6[1] ? -A_PRE : A_PRE;
        map_q = b6[0] ? -A_PRE : A_PRE;
        map_m = 3'd2;
      end
      default: ;
    endcase
  end

`ifdef MAPPER_NOISE_EN
  logic [15:0] lfsr_q;

  assign nz_i = lfsr_q[NOISE_W-1:0];
  assign nz_q = lfsr_q[NOISE_W+7:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_q <= 16'hACE1;
    else if (acc)
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`else
  assign nz_i = '0;
  assign nz_q = '0;
`endif

  // map_m is zero for guard and unsupported-mode samples, which must stay exactly zero
  assign add_i = (map_m != 3'd0) ? int'(nz_i) : 0;
  assign add_q = (map_m != 3'd0) ? int'(nz_q) : 0;

  always_comb begin
    new_s      = '0;
    new_s.i    = sat(map_i + add_i);
    new_s.q    = sat(map_q + add_q);
    new_s.sop  = isop;
    new_s.eop  = ieop;
    new_s.m    = map_m;
    new_s.subc = index_subc;
  end

  // Skid holds the older sample, so the output stage always drains it first.
  assign out_adv     = !out_vld || irdy;
  assign take_skid   = out_adv && skid_vld;
  assign take_map    = out_adv && !skid_vld && map_vld;
  assign map_to_skid = map_vld && !take_map && (!skid_vld || take_skid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_vld  <= 1'b0;
      map_s    <= '0;
      skid_vld <= 1'b0;
      skid_s   <= '0;
      out_vld  <= 1'b0;
      out_s    <= '0;
    end else begin
      if (take_skid) begin
        out_s   <= skid_s;
        out_vld <= 1'b1;
      end else if (take_map) begin
        out_s   <= map_s;
        out_vld <= 1'b1;
      end else if (out_adv) begin
        out_vld <= 1'b0;
      end

      if (map_to_skid) begin
        skid_s   <= map_s;
        skid_vld <= 1'b1;
      end else if (take_skid) begin
        skid_vld <= 1'b0;
      end

      if (acc) begin
        map_s   <= new_s;
        map_vld <= 1'b1;
      end else if (take_map || map_to_skid) begin
        map_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= 3'd0;
      cnt_q      <= '0;
      eop_seen_q <= 1'b0;
      err_frame  <= 1'b0;
      err_mode   <= 1'b0;
    end else if (acc) begin
      if (isop)
        mode_q <= index_M;
      cnt_q      <= (cur_idx == LAST) ? '0 : cur_idx + CW'(1);
      eop_seen_q <= ieop;
      if ((ieop && cur_idx != LAST) || (!ieop && cur_idx == LAST) ||
          (isop && cnt_q != '0 && !eop_seen_q))
        err_frame <= 1'b1;
      if (index_subc == 2'd1 && !mode_ok)
        err_mode <= 1'b1;
    end
  end

  assign oval        = out_vld;
  assign sub_i       = out_s.i;
  assign sub_q       = out_s.q;
  assign osop        = out_s.sop;
  assign oeop        = out_s.eop;
  assign oindex_M    = out_s.m;
  assign oindex_subc = out_s.subc;

endmodule

// File: tb/tb_ofdm_subc_mapper.sv
// Bench for ofdm_subc_mapper: directed vector table, framing/reset sequences, and random stalls against a reference model.
module tb_ofdm_subc_mapper;

  localparam int DW    = 12;
  localparam int FFT_N = 8;
`ifdef MAPPER_NOISE_EN
  localparam longint NOISE_TOL = 8;
`else
  localparam longint NOISE_TOL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ival = 1'b0, isop = 1'b0, ieop = 1'b0, irdy = 1'b1;
  logic [5:0] bits = '0;
  logic [2:0] index_M = '0;
  logic [1:0] index_subc = '0;
  logic ordy, oval, osop, oeop, err_frame, err_mode;
  logic signed [DW-1:0] sub_i, sub_q;
  logic [2:0] oindex_M;
  logic [1:0] oindex_subc;

  logic s_ordy, s_oval, s_osop, s_oeop, s_err_frame, s_err_mode;
  logic signed [DW-1:0] s_i, s_q;
  logic [2:0] s_m;
  logic [1:0] s_subc;

  ofdm_subc_mapper #(.FFT_N(FFT_N)) dut (
    .clk(clk), .rst(rst), .ival(ival), .ordy(ordy), .isop(isop), .ieop(ieop),
    .bits(bits), .index_M(index_M), .index_subc(index_subc), .sub_i(sub_i), .sub_q(sub_q),
    .oval(oval), .irdy(irdy), .osop(osop), .oeop(oeop), .oindex_M(oindex_M),
    .oindex_subc(oindex_subc), .err_frame(err_frame), .err_mode(err_mode));

  // Over-range amplitudes to exercise saturation
  ofdm_subc_mapper #(.FFT_N(FFT_N), .A_PIL(3000), .A_Q64(300)) dut_sat (
    .clk(clk), .rst(rst), .ival(ival), .ordy(s_ordy), .isop(isop), .ieop(ieop),
    .bits(bits), .index_M(index_M), .index_subc(index_subc), .sub_i(s_i), .sub_q(s_q),
    .oval(s_oval), .irdy(irdy), .osop(s_osop), .oeop(s_oeop), .oindex_M(s_m),
    .oindex_subc(s_subc), .err_frame(s_err_frame), .err_mode(s_err_mode));

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] i;
    logic signed [DW-1:0] q;
    logic [2:0] m;
    logic [1:0] subc;
    logic sop;
    logic eop;
  } exp_t;

  typedef struct {
    bit sop; int mode; int subc; int bv;
    int ei; int eq; int em; bit eerr;
    bit sat; int si; int sq;
  } vec_t;

  exp_t expq[$];
  exp_t mon_e;
  vec_t vt[11];
  int n_chk = 0, n_fail = 0, n_out = 0;
  int irdy_mode = 0;
  int model_mode = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_iq(input string name, input longint act, input longint exp, input bit exact);
    longint tol;
    tol = exact ? 0 : NOISE_TOL;
    n_chk++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gray_lvl(input int g, input int nb);
    int b = 0;
    for (int k = 0; k < nb; k++) b = b ^ (g >> k);
    b = b & ((1 << nb) - 1);
    return 2 * b - ((1 << nb) - 1);
  endfunction

  function automatic int clampv(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic exp_t model(input bit sop, input bit eop, input int subc, input int mode, input int bv);
    exp_t e;
    int vi = 0, vq = 0, vm = 0, amp = 0;
    if (subc == 1) begin
      if (mode == 1) begin
        vi = (bv & 1) ? -1024 : 1024; vm = 1;
      end else if (mode == 2) begin
        amp = 1024; vm = 2;
      end else if (mode == 4) begin
        vi = gray_lvl((bv >> 2) & 3, 2) * 512; vq = gray_lvl(bv & 3, 2) * 512; vm = 4;
      end else if (mode == 6) begin
        vi = gray_lvl((bv >> 3) & 7, 3) * 256; vq = gray_lvl(bv & 7, 3) * 256; vm = 6;
      end
    end else if (subc == 2) begin
      amp = 2000; vm = 2;
    end else if (subc == 3) begin
      amp = 1024; vm = 2;
    end
    if (amp != 0) begin
      vi = ((bv >> 1) & 1) ? -amp : amp;
      vq = (bv & 1) ? -amp : amp;
    end
    e.i = DW'(clampv(vi));
    e.q = DW'(clampv(vq));
    e.m = 3'(vm);
    e.subc = 2'(subc);
    e.sop = sop;
    e.eop = eop;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit sop, input bit eop, input int mode, input int subc, input int bv);
    bit ok = 0;
    int eff;
    ival = 1'b1; isop = sop; ieop = eop;
    index_M = 3'(mode); index_subc = 2'(subc); bits = 6'(bv);
    for (int t = 0; t < 500; t++) begin
      ok = ordy;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    check("send_accept", ok, 1);
    if (ok) begin
      if (sop) model_mode = mode;
      eff = sop ? mode : model_mode;
      expq.push_back(model(sop, eop, subc, eff, bv));
    end
    @(negedge clk);
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  task automatic send_sym(input int n, input int eop_at, input int mode);
    for (int k = 0; k < n; k++)
      send(k == 0, k == eop_at, mode, 1, int'($urandom_range(0, 63)));
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (expq.size() == 0 && !oval) break;
      @(negedge clk);
    end
    check("drain_empty", expq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    model_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    case (irdy_mode)
      0: irdy = 1'b1;
      1: irdy = ($urandom_range(0, 9) < 3);
      default: irdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && oval && irdy) begin
      n_out++;
      if (expq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mon_extra: got output i=%0d expected none", sub_i);
      end else begin
        mon_e = expq.pop_front();
        check_iq("mon_i", sub_i, mon_e.i, mon_e.m == 0);
        check_iq("mon_q", sub_q, mon_e.q, mon_e.m == 0);
        check("mon_m", oindex_M, mon_e.m);
        check("mon_subc", oindex_subc, mon_e.subc);
        check("mon_sop", osop, mon_e.sop);
        check("mon_eop", oeop, mon_e.eop);
      end
    end
  end

  initial begin
    int n0;
    vt[0]  = '{1, 6, 1, 32, 1792, -1792, 6, 0, 1, 2047, -2048};
    vt[1]  = '{1, 1, 1, 1, -1024, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{1, 1, 1, 0, 1024, 0, 1, 0, 0, 0, 0};
    vt[3]  = '{1, 2, 2, 1, 2000, -2000, 2, 0, 1, 2047, -2048};
    vt[4]  = '{1, 2, 1, 2, -1024, 1024, 2, 0, 0, 0, 0};
    vt[5]  = '{1, 4, 1, 7, -512, 512, 4, 0, 0, 0, 0};
    vt[6]  = '{0, 6, 1, 8, 1536, -1536, 4, 0, 0, 0, 0};
    vt[7]  = '{1, 2, 0, 3, 0, 0, 0, 0, 1, 0, 0};
    vt[8]  = '{1, 6, 3, 3, -1024, -1024, 2, 0, 0, 0, 0};
    vt[9]  = '{1, 6, 1, 30, -768, 256, 6, 0, 1, -900, 300};
    vt[10] = '{1, 3, 1, 5, 0, 0, 0, 1, 0, 0, 0};

    // Reset state, before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_oval", oval, 0);
    check("rst_sub_i", sub_i, 0);
    check("rst_sub_q", sub_q, 0);
    check("rst_osop", osop, 0);
    check("rst_oeop", oeop, 0);
    check("rst_oindex_M", oindex_M, 0);
    check("rst_oindex_subc", oindex_subc, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_err_mode", err_mode, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ordy", ordy, 1);

    // Directed vectors with exact two-cycle latency
    for (int v = 0; v < 11; v++) begin
      send(vt[v].sop, 0, vt[v].mode, vt[v].subc, vt[v].bv);
      check("vec_lat_early", oval, 0);
      @(posedge clk);
      @(negedge clk);
      check("vec_oval", oval, 1);
      check_iq("vec_i", sub_i, vt[v].ei, vt[v].em == 0);
      check_iq("vec_q", sub_q, vt[v].eq, vt[v].em == 0);
      check("vec_m", oindex_M, vt[v].em);
      check("vec_err_mode", err_mode, vt[v].eerr);
      if (vt[v].sat) begin
        check_iq("sat_i", s_i, vt[v].si, vt[v].si == 0);
        check_iq("sat_q", s_q, vt[v].sq, vt[v].sq == 0);
      end
    end
    @(negedge clk);

    // Fill the pipeline with irdy low, then reset mid-symbol
    irdy_mode = 2;
    @(posedge clk);
    @(negedge clk);
    send(1, 0, 4, 1, 5);
    send(0, 0, 4, 1, 6);
    send(0, 0, 4, 1, 7);
    check("bp_ordy", ordy, 0);
    check("bp_oval", oval, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_oval", oval, 0);
    check("mid_rst_sub_i", sub_i, 0);
    check("mid_rst_sub_q", sub_q, 0);
    check("mid_rst_err_mode", err_mode, 0);
    check("mid_rst_oindex_M", oindex_M, 0);
    expq.delete();
    model_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    irdy_mode = 0;
    check("mid_rst_ordy", ordy, 1);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_stale", oval, 0);

    // Framing: good, short, good again (sticky)
    do_reset();
    send_sym(8, 7, 4);
    drain();
    check("frame_good", err_frame, 0);
    send_sym(7, 6, 4);
    drain();
    check("frame_short", err_frame, 1);
    send_sym(8, 7, 4);
    drain();
    check("frame_sticky", err_frame, 1);

    do_reset();
    send_sym(8, -1, 2);
    drain();
    check("frame_no_eop", err_frame, 1);

    do_reset();
    send_sym(3, -1, 2);
    drain();
    check("frame_partial_ok", err_frame, 0);
    send_sym(8, 7, 2);
    drain();
    check("frame_early_sop", err_frame, 1);

    // Random stalls: 3 QAM16 symbols then 4 mixed-mode symbols
    do_reset();
    irdy_mode = 1;
    n0 = n_out;
    for (int s = 0; s < 7; s++) begin
      int md;
      if (s < 3) md = 4;
      else begin
        case ($urandom_range(0, 3))
          0: md = 1;
          1: md = 2;
          2: md = 4;
          default: md = 6;
        endcase
      end
      for (int k = 0; k < FFT_N; k++) begin
        int st;
        st = (k == 0) ? 1 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 1);
        send(k == 0, k == FFT_N - 1, (k == 0) ? md : int'($urandom_range(0, 7)), st,
             int'($urandom_range(0, 63)));
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
    drain();
    check("rand_out_count", n_out - n0, 7 * FFT_N);
    check("rand_err_frame", err_frame, 0);
    check("rand_err_mode", err_mode, 0);
    irdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
